// File: rtl/calc_cmd_issuer.sv
// Command FIFO plus Go/Op/Done initiator for one small_calculator.
// Issues one command at a time and returns each result on a valid/ready port.
module calc_cmd_issuer #(
  parameter int W         = 4,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64,
  parameter int DRAIN_CYC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         calc_go,
  output logic [1:0]   calc_op,
  output logic [W-1:0] calc_in1,
  output logic [W-1:0] calc_in2,
  input  logic         calc_done,
  input  logic [W-1:0] calc_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_op,
  output logic         res_timeout,
  output logic         busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int CMAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
  localparam int TW   = $clog2(CMAX);
  localparam int EW   = 2 + 2 * W;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic         go_q, go_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] in1_q, in1_d;
  logic [W-1:0] in2_q, in2_d;
  logic         rv_q, rv_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic [1:0]   rop_q, rop_d;
  logic         rto_q, rto_d;

  logic         full, empty, push, pop;
  logic [1:0]   head_op;
  logic [W-1:0] head_a, head_b;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign cmd_ready = !full && (state_q != S_DRAIN);
  assign push  = cmd_valid && cmd_ready;
  assign pop   = (state_q == S_IDLE) && !empty && !rv_q;
  assign {head_op, head_a, head_b} = mem_q[rptr_q];

  assign wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
  assign rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DRAIN;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rop_q   <= '0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rop_q   <= rop_d;
      rto_q   <= rto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_DRAIN:
        if (!calc_done && cnt_q == TW'(DRAIN_CYC - 1))
          state_d = S_IDLE;
      S_IDLE:
        if (pop) state_d = S_ISSUE;
      S_ISSUE:
        state_d = S_WAIT;
      S_WAIT:
        if (calc_done || cnt_q == TW'(TIMEOUT - 1))
          state_d = S_GAP;
      S_GAP:
        if (!calc_done) state_d = S_IDLE;
      default:
        state_d = S_DRAIN;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    go_d    = 1'b0;
    op_d    = op_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    rv_d    = rv_q && !res_ready;
    rdata_d = rdata_q;
    rop_d   = rop_q;
    rto_d   = rto_q;
    unique case (state_q)
      S_DRAIN:
        cnt_d = calc_done ? '0 : cnt_q + TW'(1);
      S_IDLE:
        if (pop) begin
          go_d  = 1'b1;
          op_d  = head_op;
          in1_d = head_a;
          in2_d = head_b;
        end
      S_ISSUE:
        cnt_d = '0;
      S_WAIT:
        if (calc_done) begin
          rdata_d = calc_out;
          rop_d   = op_q;
          rto_d   = 1'b0;
          rv_d    = 1'b1;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          rop_d   = op_q;
          rto_d   = 1'b1;
          rv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      default: ;
    endcase
  end

  assign calc_go     = go_q;
  assign calc_op     = op_q;
  assign calc_in1    = in1_q;
  assign calc_in2    = in2_q;
  assign res_valid   = rv_q;
  assign res_data    = rdata_q;
  assign res_op      = rop_q;
  assign res_timeout = rto_q;
  // DRAIN is housekeeping after reset, so it keeps busy low with the other outputs.
  assign busy = ((state_q != S_IDLE) && (state_q != S_DRAIN)) || !empty;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Directed bench for calc_cmd_issuer with a behavioural calculator model.
// Model timing (delay/length of Done) is set per scenario.
module tb_calc_cmd_issuer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         calc_go;
  logic [1:0]   calc_op;
  logic [W-1:0] calc_in1, calc_in2;
  logic         calc_done;
  logic [W-1:0] calc_out;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic [1:0]   res_op;
  logic         res_timeout;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  int           m_delay = 4;
  int           m_len   = 1;
  bit           m_en    = 1'b1;
  int           m_k     = 0;
  bit           m_arm   = 1'b0;
  logic         m_done  = 1'b0;
  logic [1:0]   m_op    = '0;
  logic [W-1:0] m_a     = '0;
  logic [W-1:0] m_b     = '0;
  logic         force_done = 1'b0;

  calc_cmd_issuer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .calc_go(calc_go), .calc_op(calc_op),
    .calc_in1(calc_in1), .calc_in2(calc_in2),
    .calc_done(calc_done), .calc_out(calc_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] calc_f(
    input logic [1:0] op, input logic [W-1:0] a, b);
    case (op)
      2'd0: calc_f = a + b;
      2'd1: calc_f = a - b;
      2'd2: calc_f = a & b;
      default: calc_f = a ^ b;
    endcase
  endfunction

  assign calc_done = m_done | force_done;
  assign calc_out  = calc_f(m_op, m_a, m_b);

  // Calculator model: Done rises m_delay negedges after Go is seen.
  always @(negedge clk) begin
    if (calc_go === 1'b1) begin
      m_k = 0; m_arm = 1'b1;
      m_op = calc_op; m_a = calc_in1; m_b = calc_in2;
    end else if (m_arm) begin
      m_k = m_k + 1;
    end
    m_done = m_arm && m_en && m_k >= m_delay && m_k < m_delay + m_len;
    if (m_arm && m_k >= m_delay + m_len) m_arm = 1'b0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [W-1:0] a, b);
    int g = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && g < 200) begin tick(); g++; end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_wait cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int lim);
    int i = 0;
    while (!res_valid && i < lim) begin tick(); i++; end
    if (!res_valid) begin
      n_tests++; n_fail++;
      $display("FAIL wait_res res_valid=%b required 1", res_valid);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({calc_go, calc_op, calc_in1, calc_in2, res_valid, res_data,
         res_op, res_timeout, cmd_ready, busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_outs go=%b in1=%h rv=%b rdy=%b busy=%b required 0",
               calc_go, calc_in1, res_valid, cmd_ready, busy);
    end
    tick(); tick();
    rst = 1'b0;
    repeat (7) tick();
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL drain7_rdy got=%b required 0", cmd_ready);
    end
    tick();
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain8_rdy got=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    bit held = 1'b1;
    int i = 0;
    m_en = 1'b1; m_delay = 4; m_len = 1; res_ready = 1'b0;
    push(2'd0, 4'd3, 4'd5);
    n_tests++;
    if (calc_go !== 1'b0) begin
      n_fail++; $display("FAIL go_early got=%b required 0", calc_go);
    end
    tick();
    n_tests++;
    if (calc_go !== 1'b1) begin
      n_fail++; $display("FAIL go_lat got=%b required 1", calc_go);
    end
    n_tests++;
    if ({calc_op, calc_in1, calc_in2} !== {2'd0, 4'd3, 4'd5}) begin
      n_fail++;
      $display("FAIL go_operands got=%h/%h/%h required 0/3/5",
               calc_op, calc_in1, calc_in2);
    end
    tick();
    n_tests++;
    if (calc_go !== 1'b0) begin
      n_fail++; $display("FAIL go_width got=%b required 0", calc_go);
    end
    while (!res_valid && i < 30) begin
      if ({calc_op, calc_in1, calc_in2} !== {2'd0, 4'd3, 4'd5}) held = 1'b0;
      tick(); i++;
    end
    n_tests++;
    if (res_valid !== 1'b1 || calc_done !== 1'b1) begin
      n_fail++;
      $display("FAIL res_lat rv=%b done=%b required 1/1", res_valid, calc_done);
    end
    n_tests++;
    if ({res_data, res_op, res_timeout} !== {4'd8, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL res_basic got=%h/%h/%b required 8/0/0",
               res_data, res_op, res_timeout);
    end
    n_tests++;
    if (!held) begin
      n_fail++; $display("FAIL in_held got=0 required 1");
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || calc_in1 !== 4'd3) begin
      n_fail++;
      $display("FAIL res_consume rv=%b in1=%h required 0/3", res_valid, calc_in1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   ops [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [W-1:0] as  [5] = '{4'd3, 4'd9, 4'd12, 4'd6, 4'd15};
    logic [W-1:0] bs  [5] = '{4'd5, 4'd4, 4'd10, 4'd3, 4'd2};
    logic [W-1:0] exp [5] = '{4'd8, 4'd5, 4'd8, 4'd5, 4'd1};
    logic [W-1:0] got_d [5];
    logic [1:0]   got_o [5];
    int n = 0;
    int i = 0;
    bit reopen = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(ops[k], as[k], bs[k]);
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL fifo_full rdy=%b required 0", cmd_ready);
    end
    while (n < 5 && i < 300) begin
      if (res_valid) begin
        got_d[n] = res_data; got_o[n] = res_op; n++;
      end
      if (cmd_ready) reopen = 1'b1;
      tick(); i++;
    end
    n_tests++;
    if (n != 5) begin
      n_fail++; $display("FAIL b2b_count got=%0d required 5", n);
    end
    n_tests++;
    if (!reopen) begin
      n_fail++; $display("FAIL fifo_reopen got=0 required 1");
    end
    for (int k = 0; k < n; k++) begin
      n_tests++;
      if (got_d[k] !== exp[k] || got_o[k] !== ops[k]) begin
        n_fail++;
        $display("FAIL b2b_res%0d got=%h/%h required %h/%h",
                 k, got_d[k], got_o[k], exp[k], ops[k]);
      end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_hold();
    int gos = 0;
    res_ready = 1'b0;
    push(2'd1, 4'd2, 4'd5);
    push(2'd3, 4'd10, 4'd5);
    wait_res(40);
    n_tests++;
    if (res_data !== 4'd13 || res_op !== 2'd1) begin
      n_fail++;
      $display("FAIL hold_res1 got=%h/%h required d/1", res_data, res_op);
    end
    repeat (10) begin
      tick();
      if (calc_go) gos++;
    end
    n_tests++;
    if (gos != 0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_block gos=%0d rv=%b required 0/1", gos, res_valid);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || calc_go !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_pulse rv=%b go=%b required 0/0", res_valid, calc_go);
    end
    tick();
    n_tests++;
    if (calc_go !== 1'b1 || calc_in1 !== 4'd10) begin
      n_fail++;
      $display("FAIL hold_next go=%b in1=%h required 1/a", calc_go, calc_in1);
    end
    wait_res(40);
    n_tests++;
    if (res_data !== 4'd15 || res_op !== 2'd3) begin
      n_fail++;
      $display("FAIL hold_res2 got=%h/%h required f/3", res_data, res_op);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    m_en = 1'b0;
    res_ready = 1'b0;
    push(2'd2, 4'd7, 4'd7);
    tick();
    n_tests++;
    if (calc_go !== 1'b1) begin
      n_fail++; $display("FAIL to_go got=%b required 1", calc_go);
    end
    repeat (64) tick();
    n_tests++;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL to_early rv=%b required 0", res_valid);
    end
    tick();
    n_tests++;
    if ({res_valid, res_data, res_timeout, res_op} !== {1'b1, 4'd0, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL to_res rv=%b d=%h to=%b op=%h required 1/0/1/2",
               res_valid, res_data, res_timeout, res_op);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    m_en = 1'b1;
  endtask

  task automatic test_done_held();
    int nres = 0;
    int ngo = 0;
    int ovl = 0;
    logic [W-1:0] d [2] = '{4'd0, 4'd0};
    m_delay = 4; m_len = 3; res_ready = 1'b1;
    push(2'd0, 4'd4, 4'd4);
    push(2'd0, 4'd1, 4'd1);
    repeat (60) begin
      if (calc_go) ngo++;
      if (calc_go && calc_done) ovl++;
      if (res_valid) begin
        if (nres < 2) d[nres] = res_data;
        nres++;
      end
      tick();
    end
    n_tests++;
    if (nres != 2 || ngo != 2) begin
      n_fail++;
      $display("FAIL held_count res=%0d go=%0d required 2/2", nres, ngo);
    end
    n_tests++;
    if (ovl != 0) begin
      n_fail++; $display("FAIL held_overlap got=%0d required 0", ovl);
    end
    n_tests++;
    if (d[0] !== 4'd8 || d[1] !== 4'd2) begin
      n_fail++;
      $display("FAIL held_data got=%h/%h required 8/2", d[0], d[1]);
    end
    m_len = 1; res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int gos = 0;
    m_delay = 10; m_len = 1; res_ready = 1'b1;
    push(2'd0, 4'd1, 4'd2);
    push(2'd0, 4'd3, 4'd3);
    tick(); tick();
    #2 rst = 1'b1;
    m_en = 1'b0;
    #1;
    n_tests++;
    if ({calc_go, calc_op, calc_in1, calc_in2, res_valid, res_data,
         res_op, res_timeout, cmd_ready, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outs go=%b in1=%h rv=%b rdy=%b busy=%b required 0",
               calc_go, calc_in1, res_valid, cmd_ready, busy);
    end
    tick();
    rst = 1'b0;
    repeat (3) begin tick(); if (calc_go) gos++; end
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    repeat (7) begin tick(); if (calc_go) gos++; end
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL stale_drain rdy=%b required 0", cmd_ready);
    end
    tick();
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_done rdy=%b busy=%b required 1/0", cmd_ready, busy);
    end
    repeat (5) begin tick(); if (calc_go) gos++; end
    n_tests++;
    if (gos != 0) begin
      n_fail++; $display("FAIL fifo_flushed gos=%0d required 0", gos);
    end
    m_en = 1'b1; m_delay = 4;
    push(2'd0, 4'd2, 4'd2);
    res_ready = 1'b0;
    wait_res(40);
    n_tests++;
    if (res_data !== 4'd4 || res_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_res got=%h/%b required 4/0", res_data, res_timeout);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_timeout();
    test_done_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
